// File: rtl/block_sync_rx_if.sv
// rtl/block_sync_rx_if.sv - gearbox-side header stream and lock/slip handshake for one lane
interface block_sync_rx_if #(
    parameter int HEAD_W = 2
);
    logic              valid_i;
    logic              signal_v_i;
    logic [HEAD_W-1:0] head_i;
    logic              slip_v_o;
    logic              lock_v_o;

    modport master (
        output valid_i,
        output signal_v_i,
        output head_i,
        input  slip_v_o,
        input  lock_v_o
    );

    modport slave (
        input  valid_i,
        input  signal_v_i,
        input  head_i,
        output slip_v_o,
        output lock_v_o
    );
endinterface

// File: rtl/block_sync_rx.sv
// rtl/block_sync_rx.sv - per-lane 66b sync header lock with gearbox bit-slip requests
module block_sync_rx #(
    parameter int HEAD_W      = 2,
    parameter int GOOD_N      = 64,
    parameter int WIN_N       = 1024,
    parameter int BAD_N       = 65,
    parameter int SLIP_WAIT_N = 2
) (
    input  logic          clk,
    input  logic          nreset,
    block_sync_rx_if.slave rx
);
    localparam int SH_W  = $clog2(WIN_N + 1);
    localparam int INV_W = $clog2(BAD_N + 1);
    localparam int SW_W  = $clog2(SLIP_WAIT_N + 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_TEST,
        ST_SLIP,
        ST_SLIP_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0]  inv_cnt_q, inv_cnt_d;
    logic [SW_W-1:0]   slip_cnt_q, slip_cnt_d;
    logic              lock_q, lock_d;
    logic              slip_q, slip_d;

    logic              head_ok;
    logic [SH_W-1:0]   sh_inc;
    logic [INV_W-1:0]  inv_inc;
    logic [SW_W-1:0]   slip_inc;

    assign head_ok  = (rx.head_i == HEAD_W'(1)) || (rx.head_i == HEAD_W'(2));
    // Saturating increments so a misconfigured window can never wrap a counter.
    assign sh_inc   = (sh_cnt_q == '1)   ? sh_cnt_q   : sh_cnt_q + SH_W'(1);
    assign inv_inc  = (inv_cnt_q == '1)  ? inv_cnt_q  : inv_cnt_q + INV_W'(1);
    assign slip_inc = (slip_cnt_q == '1) ? slip_cnt_q : slip_cnt_q + SW_W'(1);

    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        slip_cnt_d = slip_cnt_q;
        lock_d     = lock_q;
        slip_d     = 1'b0;

        if (!rx.signal_v_i) begin
            state_d    = ST_INIT;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            slip_cnt_d = '0;
            lock_d     = 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_d    = ST_TEST;
                    sh_cnt_d   = '0;
                    inv_cnt_d  = '0;
                    slip_cnt_d = '0;
                    lock_d     = 1'b0;
                end
                ST_TEST: begin
                    if (rx.valid_i) begin
                        if (!lock_q) begin
                            if (head_ok) begin
                                if (sh_inc == SH_W'(GOOD_N)) begin
                                    lock_d    = 1'b1;
                                    sh_cnt_d  = '0;
                                    inv_cnt_d = '0;
                                end else begin
                                    sh_cnt_d = sh_inc;
                                end
                            end else begin
                                state_d   = ST_SLIP;
                                slip_d    = 1'b1;
                                sh_cnt_d  = '0;
                                inv_cnt_d = '0;
                            end
                        // Losing lock is tested first so it wins over a coinciding window end.
                        end else if (!head_ok && (inv_inc == INV_W'(BAD_N))) begin
                            state_d   = ST_SLIP;
                            slip_d    = 1'b1;
                            lock_d    = 1'b0;
                            sh_cnt_d  = '0;
                            inv_cnt_d = '0;
                        end else if (sh_inc == SH_W'(WIN_N)) begin
                            sh_cnt_d  = '0;
                            inv_cnt_d = '0;
                        end else begin
                            sh_cnt_d = sh_inc;
                            if (!head_ok) begin
                                inv_cnt_d = inv_inc;
                            end
                        end
                    end
                end
                ST_SLIP: begin
                    state_d    = ST_SLIP_WAIT;
                    lock_d     = 1'b0;
                    sh_cnt_d   = '0;
                    inv_cnt_d  = '0;
                    slip_cnt_d = '0;
                end
                ST_SLIP_WAIT: begin
                    if (rx.valid_i) begin
                        if (slip_inc == SW_W'(SLIP_WAIT_N)) begin
                            state_d    = ST_TEST;
                            slip_cnt_d = '0;
                            sh_cnt_d   = '0;
                            inv_cnt_d  = '0;
                        end else begin
                            slip_cnt_d = slip_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    lock_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_INIT;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            slip_cnt_q <= '0;
            lock_q     <= 1'b0;
            slip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            slip_cnt_q <= slip_cnt_d;
            lock_q     <= lock_d;
            slip_q     <= slip_d;
        end
    end

    assign rx.lock_v_o = lock_q;
    assign rx.slip_v_o = slip_q;
endmodule

// File: tb/tb_block_sync_rx.sv
// tb/tb_block_sync_rx.sv - directed checks of block_sync_rx lock, slip, window and reset behaviour
module tb_block_sync_rx;
    logic clk;
    logic nreset;

    block_sync_rx_if #(.HEAD_W(2)) bif ();

    block_sync_rx #(
        .HEAD_W(2), .GOOD_N(64), .WIN_N(1024), .BAD_N(65), .SLIP_WAIT_N(2)
    ) dut (
        .clk   (clk),
        .nreset(nreset),
        .rx    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int slip_seen = 0;
    int dbl_slip = 0;
    int lock_drops = 0;
    logic prev_slip = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: present a header, then look at the outputs 1ns after the sampling edge.
    task automatic step(input logic v, input logic [1:0] h);
        bif.valid_i = v;
        bif.head_i  = h;
        @(posedge clk);
        #1;
        if (bif.slip_v_o === 1'b1) begin
            slip_seen++;
            if (prev_slip) dbl_slip++;
        end
        prev_slip = (bif.slip_v_o === 1'b1);
    endtask

    task automatic acquire(input bit drops);
        int base;
        base = slip_seen;
        for (int i = 0; i < 64; i++) begin
            if (drops && ($urandom_range(0, 5) == 0)) step(1'b0, 2'b11);
            step(1'b1, (i % 2) ? 2'b10 : 2'b01);
            if (i == 62) check("acq_lock_after_63", {31'd0, bif.lock_v_o}, 32'd0);
        end
        check("acq_lock_after_64", {31'd0, bif.lock_v_o}, 32'd1);
        check("acq_no_slip", slip_seen - base, 32'd0);
    endtask

    initial begin
        int base;
        nreset         = 1'b0;
        bif.valid_i    = 1'b0;
        bif.signal_v_i = 1'b0;
        bif.head_i     = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_lock", {31'd0, bif.lock_v_o}, 32'd0);
        check("reset_slip", {31'd0, bif.slip_v_o}, 32'd0);
        nreset = 1'b1;

        // Acquisition with valid_i gaps
        bif.signal_v_i = 1'b1;
        step(1'b0, 2'b00);
        acquire(1'b1);

        // Two windows, each with 64 invalid headers, the last on the window end
        base = slip_seen;
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 1024; i++) begin
                step(1'b1, ((i % 16) == 15) ? 2'b00 : 2'b01);
                if (bif.lock_v_o !== 1'b1) lock_drops++;
            end
            check(w == 0 ? "tol_lock_win1" : "tol_lock_win2", {31'd0, bif.lock_v_o}, 32'd1);
        end
        check("tol_lock_drops", lock_drops, 32'd0);
        check("tol_no_slip", slip_seen - base, 32'd0);

        // 65th invalid header is also the 1024th header of the window
        base = slip_seen;
        for (int i = 0; i < 1024; i++) begin
            step(1'b1, (i >= 959) ? 2'b11 : 2'b10);
            if (i == 1022) begin
                check("edge_lock_64th_bad", {31'd0, bif.lock_v_o}, 32'd1);
                check("edge_slip_64th_bad", {31'd0, bif.slip_v_o}, 32'd0);
            end
        end
        check("edge_lock_65th_bad", {31'd0, bif.lock_v_o}, 32'd0);
        check("edge_slip_65th_bad", {31'd0, bif.slip_v_o}, 32'd1);
        step(1'b0, 2'b11);
        check("edge_slip_one_cycle", {31'd0, bif.slip_v_o}, 32'd0);

        // Two headers after a slip are discarded, the third is tested
        base = slip_seen;
        step(1'b1, 2'b11);
        step(1'b1, 2'b11);
        check("wait_discard", slip_seen - base, 32'd0);
        step(1'b1, 2'b11);
        check("wait_third_tested", {31'd0, bif.slip_v_o}, 32'd1);
        step(1'b0, 2'b00);

        // Unlocked slip after 10 valid headers
        step(1'b1, 2'b01);
        step(1'b1, 2'b10);
        base = slip_seen;
        for (int i = 0; i < 10; i++) step(1'b1, (i % 2) ? 2'b10 : 2'b01);
        check("unl_no_slip_good", slip_seen - base, 32'd0);
        step(1'b1, 2'b11);
        check("unl_slip", {31'd0, bif.slip_v_o}, 32'd1);
        check("unl_lock", {31'd0, bif.lock_v_o}, 32'd0);
        step(1'b0, 2'b00);
        check("unl_slip_one_cycle", {31'd0, bif.slip_v_o}, 32'd0);

        // Mid-window loss: 65 consecutive invalid headers
        step(1'b1, 2'b01);
        step(1'b1, 2'b10);
        acquire(1'b0);
        base = slip_seen;
        for (int i = 0; i < 65; i++) begin
            step(1'b1, 2'b00);
            if (i == 63) begin
                check("loss_lock_64th", {31'd0, bif.lock_v_o}, 32'd1);
                check("loss_slip_64th", slip_seen - base, 32'd0);
            end
        end
        check("loss_lock_65th", {31'd0, bif.lock_v_o}, 32'd0);
        check("loss_slip_65th", {31'd0, bif.slip_v_o}, 32'd1);
        step(1'b0, 2'b00);

        // Signal loss during SLIP_WAIT
        base = slip_seen;
        step(1'b1, 2'b01);
        bif.signal_v_i = 1'b0;
        step(1'b1, 2'b01);
        check("sigw_lock", {31'd0, bif.lock_v_o}, 32'd0);
        check("sigw_no_slip", slip_seen - base, 32'd0);
        bif.signal_v_i = 1'b1;
        step(1'b0, 2'b00);
        acquire(1'b0);

        // Signal loss while locked
        base = slip_seen;
        step(1'b1, 2'b01);
        bif.signal_v_i = 1'b0;
        step(1'b1, 2'b10);
        check("sigl_lock", {31'd0, bif.lock_v_o}, 32'd0);
        check("sigl_no_slip", slip_seen - base, 32'd0);
        bif.signal_v_i = 1'b1;
        step(1'b0, 2'b00);
        acquire(1'b0);

        // Asynchronous reset while locked, mid-window
        for (int i = 0; i < 5; i++) step(1'b1, 2'b01);
        #2;
        nreset = 1'b0;
        #1;
        check("arst_lock", {31'd0, bif.lock_v_o}, 32'd0);
        check("arst_slip_locked", {31'd0, bif.slip_v_o}, 32'd0);
        @(posedge clk);
        #1;
        nreset = 1'b1;
        prev_slip = 1'b0;

        // Asynchronous reset during a slip pulse
        step(1'b0, 2'b00);
        step(1'b1, 2'b11);
        check("arst_slip_before", {31'd0, bif.slip_v_o}, 32'd1);
        #2;
        nreset = 1'b0;
        #1;
        check("arst_slip_pulse", {31'd0, bif.slip_v_o}, 32'd0);

        check("no_back_to_back_slip", dbl_slip, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
